padder_pipe: RTL and testbench

//  Parametrised pipelined adder: successor to the 8-bit half adder, generalised in width and depth.

---
 rtl/padder_pkg.sv | 35 +++
 rtl/padder_stage.sv | 50 +++++
 rtl/padder_pipe.sv | 111 +++++++++++
 tb/tb_padder_pipe.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/padder_pkg.sv
// Shared types and helpers for the padder_pipe pipelined adder.
// Build option: PADDER_SAT_EN enables output saturation in padder_pipe.
package padder_pkg;

    localparam int MAX_WIDTH  = 64;
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STAGES = 2;
    localparam int CHUNK      = DEF_WIDTH / DEF_STAGES;

    // Per-stage control record; sum slices and pending operand slices travel beside it.
    typedef struct packed {
        logic valid;
        logic carry;
        logic a_msb;
        logic b_msb;
    } stage_ctrl_t;

    // Saturation value: all ones (unsigned), or most negative/positive two's complement value.
    function automatic logic [MAX_WIDTH-1:0] sat_value(input bit is_signed, input logic neg,
                                                       input int width);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width - 1) begin
                v[i] = is_signed ? ~neg : 1'b1;
            end else if (i == width - 1) begin
                v[i] = is_signed ? neg : 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/padder_stage.sv
// One slice of the pipelined adder: adds slice K of the operands plus incoming carry
// and registers the partial sum, carry and still-pending operand bits.
module padder_stage
    import padder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 4,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  stage_ctrl_t      ctrl_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] sum_in,
    output stage_ctrl_t      ctrl_out,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] sum_out
);

    logic [SLICE:0]   slice_sum;
    logic [WIDTH-1:0] sum_next;

    // Slice adder; lower result slices from earlier stages pass through untouched.
    always_comb begin
        slice_sum = {1'b0, a_in[K*SLICE +: SLICE]} + {1'b0, b_in[K*SLICE +: SLICE]}
                  + {{SLICE{1'b0}}, ctrl_in.carry};
        sum_next  = sum_in;
        sum_next[K*SLICE +: SLICE] = slice_sum[SLICE-1:0];
    end

    // Stage register: loads only when the whole pipe advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_out <= '0;
            a_out    <= '0;
            b_out    <= '0;
            sum_out  <= '0;
        end else if (en) begin
            ctrl_out <= '{valid: ctrl_in.valid, carry: slice_sum[SLICE],
                          a_msb: ctrl_in.a_msb, b_msb: ctrl_in.b_msb};
            a_out    <= a_in;
            b_out    <= b_in;
            sum_out  <= sum_next;
        end
    end

endmodule

// File: rtl/padder_pipe.sv
// Pipelined WIDTH-bit adder, STAGES slices, valid/ready handshake, carry/overflow flags.
// Build option: define PADDER_SAT_EN to saturate O on carry (unsigned) or overflow (signed).
module padder_pipe
    import padder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] O,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK_W = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > WIDTH) || (WIDTH % STAGES != 0) || (WIDTH > MAX_WIDTH)) begin : g_bad_cfg
        $error("padder_pipe: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH <= MAX_WIDTH");
    end

    logic        adv;
    stage_ctrl_t ctrl_q [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];

    // Every stage shifts together; a held result freezes the entire pipe.
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_ctrl_t      ctrl_d;
        logic [WIDTH-1:0] a_d;
        logic [WIDTH-1:0] b_d;
        logic [WIDTH-1:0] sum_d;

        if (k == 0) begin : g_first
            assign ctrl_d = '{valid: in_valid, carry: 1'b0, a_msb: A[WIDTH-1], b_msb: B[WIDTH-1]};
            assign a_d    = A;
            assign b_d    = B;
            assign sum_d  = '0;
        end else begin : g_next
            assign ctrl_d = ctrl_q[k-1];
            assign a_d    = a_q[k-1];
            assign b_d    = b_q[k-1];
            assign sum_d  = sum_q[k-1];
        end

        padder_stage #(
            .WIDTH (WIDTH),
            .SLICE (CHUNK_W),
            .K     (k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en       (adv),
            .ctrl_in  (ctrl_d),
            .a_in     (a_d),
            .b_in     (b_d),
            .sum_in   (sum_d),
            .ctrl_out (ctrl_q[k]),
            .a_out    (a_q[k]),
            .b_out    (b_q[k]),
            .sum_out  (sum_q[k])
        );
    end

    stage_ctrl_t      last;
    logic [WIDTH-1:0] raw;
    logic             raw_ovf;

    assign last      = ctrl_q[STAGES-1];
    assign raw       = sum_q[STAGES-1];
    assign out_valid = last.valid;
    assign cout      = last.carry;
    assign ovf       = raw_ovf;

    // Flag from the final stage register: carry out, or sign overflow from the carried operand MSBs.
    always_comb begin
        if (SIGNED) begin
            raw_ovf = (last.a_msb == last.b_msb) && (raw[WIDTH-1] != last.a_msb);
        end else begin
            raw_ovf = last.carry;
        end
    end

`ifdef PADDER_SAT_EN
    // Clamp the result whenever the raw flag fires; flags still report the raw condition.
    always_comb begin
        if (raw_ovf) begin
            O = WIDTH'(sat_value(SIGNED, last.a_msb, WIDTH));
        end else begin
            O = raw;
        end
    end
`else
    // Wrapped sum straight from the final stage.
    always_comb begin
        O = raw;
    end
`endif

endmodule

// File: tb/tb_padder_pipe.sv
// Scoreboard bench for padder_pipe: 8/2 unsigned, 8/2 signed and 16/4 unsigned instances.
module tb_padder_pipe;

`ifdef PADDER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       u_iv, u_ir, u_ov, u_or, u_c, u_v;
    logic [7:0] u_a, u_b, u_o;
    logic       s_iv, s_ir, s_ov, s_or, s_c, s_v;
    logic [7:0] s_a, s_b, s_o;
    logic        w_iv, w_ir, w_ov, w_or, w_c, w_v;
    logic [15:0] w_a, w_b, w_o;

    padder_pipe #(.WIDTH(8), .STAGES(2), .SIGNED(1'b0)) u_dut_u8 (
        .clk(clk), .rst(rst), .in_valid(u_iv), .in_ready(u_ir), .A(u_a), .B(u_b),
        .out_valid(u_ov), .out_ready(u_or), .O(u_o), .cout(u_c), .ovf(u_v));

    padder_pipe #(.WIDTH(8), .STAGES(2), .SIGNED(1'b1)) u_dut_s8 (
        .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(s_ir), .A(s_a), .B(s_b),
        .out_valid(s_ov), .out_ready(s_or), .O(s_o), .cout(s_c), .ovf(s_v));

    padder_pipe #(.WIDTH(16), .STAGES(4), .SIGNED(1'b0)) u_dut_w16 (
        .clk(clk), .rst(rst), .in_valid(w_iv), .in_ready(w_ir), .A(w_a), .B(w_b),
        .out_valid(w_ov), .out_ready(w_or), .O(w_o), .cout(w_c), .ovf(w_v));

    logic [9:0]  u_q [$];
    logic [9:0]  s_q [$];
    logic [17:0] w_q [$];
    int u_tq [$];
    int s_tq [$];
    int w_tq [$];
    bit u_lat, s_lat, w_lat, w_rand;
    logic [17:0] u_e, s_e, w_e;
    int u_t, s_t, w_t;

    task automatic compare(input string tag, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] m16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] o;
        s = {1'b0, a} + {1'b0, b};
        o = s[15:0];
        if (SAT && s[16]) o = 16'hffff;
        return {o, s[16], s[16]};
    endfunction

    always @(negedge clk) begin
        if (!rst && u_ov && u_or) begin
            if (u_q.size() == 0) begin
                checks++; errors++;
                $error("FAIL u8_unexpected got %h expected none", {u_o, u_c, u_v});
            end else begin
                u_e = 18'(u_q.pop_front());
                u_t = u_tq.pop_front();
                compare("u8_result", {8'd0, u_o, u_c, u_v}, u_e);
                if (u_lat) compare("u8_latency", 18'(cyc - u_t), 18'd2);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && s_ov && s_or) begin
            if (s_q.size() == 0) begin
                checks++; errors++;
                $error("FAIL s8_unexpected got %h expected none", {s_o, s_c, s_v});
            end else begin
                s_e = 18'(s_q.pop_front());
                s_t = s_tq.pop_front();
                compare("s8_result", {8'd0, s_o, s_c, s_v}, s_e);
                if (s_lat) compare("s8_latency", 18'(cyc - s_t), 18'd2);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && w_ov && w_or) begin
            if (w_q.size() == 0) begin
                checks++; errors++;
                $error("FAIL w16_unexpected got %h expected none", {w_o, w_c, w_v});
            end else begin
                w_e = w_q.pop_front();
                w_t = w_tq.pop_front();
                compare("w16_result", {w_o, w_c, w_v}, w_e);
                if (w_lat) compare("w16_latency", 18'(cyc - w_t), 18'd4);
            end
        end
    end

    task automatic send_u(input logic [7:0] a, input logic [7:0] b, input logic [9:0] exp);
        bit acc = 1'b0;
        int t = 0;
        u_a = a; u_b = b; u_iv = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk); acc = u_ir; t = cyc;
            @(posedge clk); #1;
            if (acc) break;
        end
        compare("u8_accept", 18'(acc), 18'd1);
        if (acc) begin u_q.push_back(exp); u_tq.push_back(t); end
        u_iv = 1'b0;
    endtask

    task automatic send_s(input logic [7:0] a, input logic [7:0] b, input logic [9:0] exp);
        bit acc = 1'b0;
        int t = 0;
        s_a = a; s_b = b; s_iv = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk); acc = s_ir; t = cyc;
            @(posedge clk); #1;
            if (acc) break;
        end
        compare("s8_accept", 18'(acc), 18'd1);
        if (acc) begin s_q.push_back(exp); s_tq.push_back(t); end
        s_iv = 1'b0;
    endtask

    task automatic send_w(input logic [15:0] a, input logic [15:0] b, input logic [17:0] exp);
        bit acc = 1'b0;
        int t = 0;
        w_a = a; w_b = b; w_iv = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk); acc = w_ir; t = cyc;
            @(posedge clk); #1;
            if (w_rand) w_or = 1'($urandom_range(0, 1));
            if (acc) break;
        end
        compare("w16_accept", 18'(acc), 18'd1);
        if (acc) begin w_q.push_back(exp); w_tq.push_back(t); end
        w_iv = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            if (u_q.size() == 0 && s_q.size() == 0 && w_q.size() == 0) break;
            @(posedge clk); #1;
        end
        compare("drain_u8", 18'(u_q.size()), 18'd0);
        compare("drain_s8", 18'(s_q.size()), 18'd0);
        compare("drain_w16", 18'(w_q.size()), 18'd0);
    endtask

    initial begin
        rst = 1'b1;
        u_iv = 1'b0; u_a = 8'd0; u_b = 8'd0; u_or = 1'b1;
        s_iv = 1'b0; s_a = 8'd0; s_b = 8'd0; s_or = 1'b1;
        w_iv = 1'b0; w_a = 16'd0; w_b = 16'd0; w_or = 1'b1;
        u_lat = 1'b0; s_lat = 1'b0; w_lat = 1'b0; w_rand = 1'b0;
        #12 rst = 1'b0;

        @(negedge clk);
        compare("rst_u8_out", {8'd0, u_o, u_c, u_v}, 18'd0);
        compare("rst_u8_valid", 18'(u_ov), 18'd0);
        compare("rst_u8_ready", 18'(u_ir), 18'd1);
        compare("rst_s8_valid", 18'(s_ov), 18'd0);
        compare("rst_w16_out", {w_o, w_c, w_v}, 18'd0);
        @(posedge clk); #1;

        u_lat = 1'b1;
        send_u(8'd50, 8'd37, {8'd87, 1'b0, 1'b0});
        drain();
        send_u(8'd200, 8'd100, {(SAT ? 8'd255 : 8'd44), 1'b1, 1'b1});
        drain();

        s_lat = 1'b1;
        send_s(8'd100, 8'd50, {(SAT ? 8'h7f : 8'h96), 1'b0, 1'b1});
        send_s(8'h9c, 8'hce, {(SAT ? 8'h80 : 8'h6a), 1'b1, 1'b1});
        drain();

        // Backpressure: first result is presented right as out_ready drops.
        u_lat = 1'b0;
        send_u(8'd1, 8'd2, {8'd3, 1'b0, 1'b0});
        send_u(8'd10, 8'd20, {8'd30, 1'b0, 1'b0});
        u_or = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compare("stall_in_ready", 18'(u_ir), 18'd0);
            compare("stall_out_valid", 18'(u_ov), 18'd1);
            compare("stall_hold_o", 18'(u_o), 18'd3);
            @(posedge clk); #1;
        end
        u_or = 1'b1;
        send_u(8'd100, 8'd27, {8'd127, 1'b0, 1'b0});
        send_u(8'd255, 8'd1, {(SAT ? 8'd255 : 8'd0), 1'b1, 1'b1});
        drain();

        // Reset with two results in flight.
        u_lat = 1'b1;
        send_u(8'd5, 8'd6, {8'd11, 1'b0, 1'b0});
        send_u(8'd7, 8'd8, {8'd15, 1'b0, 1'b0});
        #1 rst = 1'b1;
        #1;
        compare("rst_mid_valid", 18'(u_ov), 18'd0);
        compare("rst_mid_o", {8'd0, u_o, u_c, u_v}, 18'd0);
        u_q.delete(); u_tq.delete();
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        send_u(8'd1, 8'd1, {8'd2, 1'b0, 1'b0});
        drain();

        w_lat = 1'b1;
        send_w(16'd1000, 16'd2345, {16'd3345, 1'b0, 1'b0});
        send_w(16'hffff, 16'h0001, {(SAT ? 16'hffff : 16'h0000), 1'b1, 1'b1});
        drain();
        w_lat = 1'b0;
        w_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            send_w(ra, rb, m16(ra, rb));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                w_or = 1'($urandom_range(0, 1));
            end
        end
        w_rand = 1'b0;
        w_or = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
